rr_mux_arbiter_4ch: RTL
=======================

// Module: rr_mux_arbiter_4ch
// PURPOSE
//  Upstream stage for the 4:1 data mux: round-robin arbiter over four requesters (a..d).
//  Selects one requester per accepted transfer and registers its data with the
//  matching 2-bit select code (00=a, 01=b, 10=c, 11=d), which is the downstream mux's sel encoding.
//  Provides one output register slot with valid/ready backpressure and a fairness guarantee.
// PARAMETERS
//  WIDTH   4   data width of each requester and of out_data
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   4      request per channel; bit0=a, bit1=b, bit2=c, bit3=d
//  in_a       in   WIDTH  channel a data, valid when req[0]
//  in_b       in   WIDTH  channel b data, valid when req[1]
//  in_c       in   WIDTH  channel c data, valid when req[2]
//  in_d       in   WIDTH  channel d data, valid when req[3]
//  gnt        out  4      one-hot grant, combinational; req[i]&gnt[i] = transfer accepted this cycle
//  out_data   out  WIDTH  registered data of the last granted channel
//  sel        out  2      registered index of the channel that produced out_data
//  out_valid  out  1      out_data/sel hold a transfer
//  out_ready  in   1      downstream accepts when out_valid & out_ready
// BEHAVIOUR
//  Reset (rst_n low, async): out_valid=0, out_data=0, sel=2'b00, ptr=2'd0; gnt=0 while rst_n low.
//  Reset mid-operation discards any held transfer; no partial output after release.
//  State: slot EMPTY (out_valid=0) / FULL (out_valid=1); 2-bit priority pointer ptr.
//  can_load = ~out_valid | out_ready.
//  Arbitration (combinational): if can_load & |req, gnt = one-hot of the first set req bit
//   scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); else gnt=0. gnt never has >1 bit set.
//  On accept (|gnt) at clock edge: out_data <= data of granted channel, sel <= its index,
//   out_valid <= 1, ptr <= index+1 (mod 4; index 3 wraps to 0).
//  No accept & out_valid & out_ready: out_valid <= 0 (FULL->EMPTY); out_data, sel keep last value.
//  Accept while out_valid & out_ready: simultaneous pop+push, out_valid stays 1 (FULL->FULL).
//  out_valid & ~out_ready: gnt=0; out_data, sel, ptr held stable (backpressure).
//  EMPTY & no req: nothing changes.
//  Latency: accept in cycle N -> out_valid/out_data/sel visible after edge N (1 cycle).
//  Throughput: one transfer per cycle with out_ready held high.
//  Fairness: a channel holding req high is granted within at most 4 accepts.
//  req may drop before grant with no side effect; ptr only moves on accept.
//  ptr is internal; it is observable through the grant order.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, sel=00, out_data=0 immediately, gnt=0.
//  2 Round-robin: req=4'b1111, in_a..d=1,2,3,4, out_ready=1 -> sel sequence 00,01,10,11,00;
//    out_data sequence 1,2,3,4,1; one accept per cycle.
//  3 Skip/wrap: ptr=2 after a grant to b, req=4'b0011 -> grant a (sel=00) next, then b, then a.
//  4 Backpressure: out_valid=1, out_ready=0 for 5 cycles with req=4'b1111 -> gnt=0;
//    out_data/sel frozen; on out_ready=1 the held word pops and the next channel is granted the same cycle.
//  5 Single requester: req=4'b1000, in_d=4'hA, out_ready=1 -> gnt=4'b1000 every cycle; sel=11; out_data=A.
//  6 Drain: last accept then req=0, out_ready=1 -> out_valid drops after one cycle; sel/out_data hold.

Source files
------------

// File: rtl/rr_mux_arbiter_4ch.sv
// rr_mux_arbiter_4ch: round-robin arbiter over four requesters feeding one registered output slot
module rr_mux_arbiter_4ch #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic [3:0]       gnt,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [1:0]       ptr;
    logic [1:0]       off;
    logic [1:0]       idx;
    logic [7:0]       dbl;
    logic [3:0]       rot;
    logic             accept;
    logic [WIDTH-1:0] gdata;
    always_comb begin
        dbl    = {req, req} >> ptr;
        rot    = dbl[3:0];
        off    = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        idx    = ptr + off;
        accept = rst_n & (~out_valid | out_ready) & (|req);
        gnt    = accept ? 4'b0001 << idx : 4'b0000;
        gdata  = idx == 2'd0 ? in_a : idx == 2'd1 ? in_b : idx == 2'd2 ? in_c : in_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sel       <= 2'b00;
            ptr       <= 2'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= gdata;
            sel       <= idx;
            ptr       <= idx + 2'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
